register_xfer_arbiter: RTL

REGISTER_XFER_ARBITER -- requirements
Module: register_xfer_arbiter

---
 rtl/register_xfer_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/register_xfer_arbiter.sv
// register_xfer_arbiter
//
// Arbitrates two requesters for register-to-register transfers over a shared
// 16-bit bus and sequences the register control lines for each transfer.
// A transfer drives the source onto the bus for one cycle (DRIVE), then holds
// the drive and pulses the destination load for one cycle (LOAD). Completion
// is reported one cycle later with xfer_done/xfer_id/xfer_err.
//
// Register codes: 0=A 1=B 2=C 3=P 4=S 5=ST, 6-7 invalid.
//
// Ports:
//   clock_in              sole clock
//   reset_in              synchronous active-high reset
//   reqN_valid/src/dst    requester N transfer request (N = 0, 1)
//   reqN_ready            combinational grant, high when request N is accepted
//   bus_hold              another master owns the bus; blocks new grants
//   Register_Control_Bus  [5:0] load A..ST, [11:6] drive A..ST onto bus
//   xfer_done             one-cycle completion pulse
//   xfer_id               requester index of the completing transfer
//   xfer_err              with xfer_done: the transfer had an invalid code
//
// Configuration:
//   REG_XFER_ROUND_ROBIN_EN  defined   -> round-robin between requesters
//                            undefined -> fixed priority, requester 0 wins
//
// State | Meaning
// IDLE  | no transfer in flight, grants allowed when bus_hold=0
// DRIVE | source register drives the bus
// LOAD  | source still drives, destination register loads

module register_xfer_arbiter (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        req0_valid,
    input  logic [2:0]  req0_src,
    input  logic [2:0]  req0_dst,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_src,
    input  logic [2:0]  req1_dst,
    output logic        req1_ready,
    input  logic        bus_hold,
    output logic [11:0] Register_Control_Bus,
    output logic        xfer_done,
    output logic        xfer_id,
    output logic        xfer_err
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    state_t      state_q, state_d;
    logic [2:0]  src_q, src_d;
    logic [2:0]  dst_q, dst_d;
    logic        id_q, id_d;
    logic [11:0] ctrl_q, ctrl_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xid_q, xid_d;

    logic        grant;
    logic        pick1;
    logic        accept;
    logic        acc_id;
    logic [2:0]  acc_src;
    logic [2:0]  acc_dst;
    logic        acc_bad;

`ifdef REG_XFER_ROUND_ROBIN_EN
    // ptr_q names the requester preferred when both are valid; it flips to
    // the other requester on every acceptance.
    logic ptr_q, ptr_d;
    assign pick1 = req1_valid & (~req0_valid | ptr_q);
`else
    assign pick1 = req1_valid & ~req0_valid;
`endif

    assign grant      = (state_q == IDLE) & ~bus_hold & ~reset_in;
    assign req0_ready = grant & req0_valid & ~pick1;
    assign req1_ready = grant & pick1;
    assign accept     = req0_ready | req1_ready;
    assign acc_id     = req1_ready;
    assign acc_src    = acc_id ? req1_src : req0_src;
    assign acc_dst    = acc_id ? req1_dst : req0_dst;
    assign acc_bad    = (acc_src > 3'd5) | (acc_dst > 3'd5);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        id_d    = id_q;
        ctrl_d  = 12'h000;
        done_d  = 1'b0;
        err_d   = 1'b0;
        xid_d   = xid_q;
`ifdef REG_XFER_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef REG_XFER_ROUND_ROBIN_EN
                    ptr_d = ~acc_id;
`endif
                    if (acc_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        xid_d  = acc_id;
                    end else if (acc_src == acc_dst) begin
                        done_d = 1'b1;
                        xid_d  = acc_id;
                    end else begin
                        state_d = DRIVE;
                        src_d   = acc_src;
                        dst_d   = acc_dst;
                        id_d    = acc_id;
                        // bit 6 is the drive line of code 0
                        ctrl_d  = 12'h040 << acc_src;
                    end
                end
            end
            DRIVE: begin
                state_d = LOAD;
                ctrl_d  = (12'h040 << src_q) | (12'h001 << dst_q);
            end
            LOAD: begin
                state_d = IDLE;
                done_d  = 1'b1;
                xid_d   = id_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            src_q   <= 3'd0;
            dst_q   <= 3'd0;
            id_q    <= 1'b0;
            ctrl_q  <= 12'h000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            xid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            id_q    <= id_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            xid_q   <= xid_d;
        end
    end

`ifdef REG_XFER_ROUND_ROBIN_EN
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign Register_Control_Bus = ctrl_q;
    assign xfer_done            = done_q;
    assign xfer_id              = xid_q;
    assign xfer_err             = err_q;

endmodule
